// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream Wishbone loader.
//   state_e        : top-level frame/response FSM states
//   ST_OK / ST_ERR : status bytes returned per command ('K' / 'E')
//   DEF_CMD_*      : default command byte values
//   rd_byte()      : picks the next read-data byte to send, MSB first
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_e;

  localparam logic [7:0] ST_OK      = 8'h4B;
  localparam logic [7:0] ST_ERR     = 8'h45;
  localparam logic [7:0] DEF_CMD_WR = 8'h57;
  localparam logic [7:0] DEF_CMD_RD = 8'h52;

  // 'remaining' counts bytes still to send; 4 selects the MSB.
  function automatic logic [7:0] rd_byte(input logic [31:0] word, input logic [2:0] remaining);
    logic [7:0] b;
    case (remaining)
      3'd4:    b = word[31:24];
      3'd3:    b = word[23:16];
      3'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_master_cycle.sv
// Single Wishbone classic bus cycle with ack timeout.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse; cycle begins on the next clock
//   we, adr, dat        : cycle attributes; adr/dat must stay stable while cyc is high
//   done                : ack seen this cycle (cyc drops next cycle)
//   timed_out           : TIMEOUT cycles elapsed without ack (cyc drops next cycle)
//   rdata               : read data captured on a read ack
//   bus_*               : Wishbone initiator signals
module wb_master_cycle #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] rdata,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_w,
  input  logic [31:0] bus_dat_r,
  input  logic        bus_ack
);

  localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

  logic        cyc_q;
  logic        we_q;
  logic [15:0] cnt_q;
  logic [31:0] rdata_q;
  logic        hit_ack;
  logic        expire;

  // ack has priority over the timeout in the same cycle.
  assign hit_ack = cyc_q & bus_ack;
  assign expire  = cyc_q & ~bus_ack & (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (start) begin
      cyc_q <= 1'b1;
      we_q  <= we;
      cnt_q <= '0;
    end else if (cyc_q) begin
      if (hit_ack || expire) begin
        cyc_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (hit_ack && !we_q) begin
        rdata_q <= bus_dat_r;
      end
    end
  end

  assign done      = hit_ack;
  assign timed_out = expire;
  assign rdata     = rdata_q;
  assign bus_cyc   = cyc_q;
  assign bus_stb   = cyc_q;
  assign bus_we    = cyc_q & we_q;
  assign bus_sel   = cyc_q ? 4'hF : 4'h0;
  assign bus_adr   = adr;
  assign bus_dat_w = dat;

endmodule

// File: rtl/wb_byte_loader.sv
// Byte-stream to Wishbone bridge: parses command frames from an 8-bit input stream,
// issues one Wishbone read/write per frame and streams back a status byte (plus read
// data on successful reads).
//   wb_clk_i, wb_rst_ni           : clock, asynchronous active-low reset
//   in_valid, in_data, in_ready   : command byte stream (valid/ready)
//   out_valid, out_data, out_ready: response byte stream (valid/ready)
//   wbm_*                         : Wishbone initiator port
//   busy                          : FSM not idle
//   err_sticky                    : a timeout or bad command occurred since reset
module wb_byte_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  CMD_WR  = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RD  = DEF_CMD_RD
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        err_sticky
);

  state_e      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [2:0]  remaining_q, remaining_d;
  logic        err_q, err_d;

  logic        accept;
  logic        start;
  logic        done;
  logic        timed_out;
  logic [31:0] rdata;

  wb_master_cycle #(
    .TIMEOUT (TIMEOUT)
  ) u_cycle (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .start     (start),
    .we        (cmd_we_q),
    .adr       (adr_q),
    .dat       (dat_q),
    .done      (done),
    .timed_out (timed_out),
    .rdata     (rdata),
    .bus_cyc   (wbm_cyc_o),
    .bus_stb   (wbm_stb_o),
    .bus_we    (wbm_we_o),
    .bus_sel   (wbm_sel_o),
    .bus_adr   (wbm_adr_o),
    .bus_dat_w (wbm_dat_o),
    .bus_dat_r (wbm_dat_i),
    .bus_ack   (wbm_ack_i)
  );

  assign in_ready   = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == RESP);
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign err_sticky = err_q;

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    byte_cnt_d  = byte_cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    out_data_d  = out_data_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    start       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data == CMD_WR || in_data == CMD_RD) begin
            cmd_we_d   = (in_data == CMD_WR);
            byte_cnt_d = 2'd0;
            state_d    = ADDR;
          end else begin
            out_data_d  = ST_ERR;
            remaining_d = 3'd0;
            err_d       = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          adr_d      = {adr_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (cmd_we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              start   = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          dat_d      = {dat_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = BUS;
            start   = 1'b1;
          end
        end
      end
      BUS: begin
        if (done) begin
          out_data_d  = ST_OK;
          remaining_d = cmd_we_q ? 3'd0 : 3'd4;
          state_d     = RESP;
        end else if (timed_out) begin
          out_data_d  = ST_ERR;
          remaining_d = 3'd0;
          err_d       = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // out_data_q only changes on a handshake, so it is stable under backpressure.
        if (out_ready) begin
          if (remaining_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            out_data_d  = rd_byte(rdata, remaining_q);
            remaining_d = remaining_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      byte_cnt_q  <= 2'd0;
      adr_q       <= '0;
      dat_q       <= '0;
      out_data_q  <= '0;
      remaining_q <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      byte_cnt_q  <= byte_cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      out_data_q  <= out_data_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

endmodule
